// File: rtl/dvsd_pd_pkg.sv
// Shared types and constants for the registered 3-to-8 priority decoder
// with pending-request queue.
package dvsd_pd_pkg;

  localparam int CODE_W_DEF = 3;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_e;

  // Number of decoded request lines for a given code width.
  function automatic int n_lines(input int code_w);
    return 1 << code_w;
  endfunction

endpackage

// File: rtl/dvsd_lsb_sel.sv
// Combinational lowest-set-bit selector: one-hot of the lowest set bit of
// in_i, all zeros when in_i is zero.
module dvsd_lsb_sel #(
  parameter int N = 8
) (
  input  logic [N-1:0] in_i,
  output logic [N-1:0] out_o
);

  logic [N-1:0] neg;

  // x & -x isolates the lowest set bit; -0 is 0, so an empty input stays empty.
  assign neg   = ~in_i + {{(N-1){1'b0}}, 1'b1};
  assign out_o = in_i & neg;

endmodule

// File: rtl/dvsd_pd.sv
// Registered 3-to-8 priority decoder that queues every decoded request as a
// pending bit and grants them back one at a time, lowest index first.
module dvsd_pd
  import dvsd_pd_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       en,
  input  logic [CODE_W-1:0]          code_i,
  input  logic                       gs_i,
  output logic [n_lines(CODE_W)-1:0] out_o,
  output logic [n_lines(CODE_W)-1:0] pend_o,
  output logic [n_lines(CODE_W)-1:0] gnt_o,
  output logic                       gnt_valid_o,
  input  logic                       gnt_ready_i,
  output logic                       eno_o,
  output logic                       drop_o,
  output logic [CNT_W-1:0]           cnt_o,
  output logic                       dbg_state_o
);

  localparam int N = n_lines(CODE_W);

  // Handshake: a grant transfers on an edge where gnt_valid_o and gnt_ready_i
  // are both high; gnt_o is stable from the edge gnt_valid_o rises until then.

  state_e         state_q, state_d;
  logic [N-1:0]   out_q, out_d;
  logic [N-1:0]   pend_q, pend_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           eno_q, eno_d;
  logic           drop_q, drop_d;

  logic           capture;
  logic           retire;
  logic [N-1:0]   cap_mask;
  logic [N-1:0]   ret_mask;
  logic [N-1:0]   kept_mask;
  logic [N-1:0]   lowest;

  dvsd_lsb_sel #(.N(N)) u_lsb_sel (
    .in_i  (pend_q),
    .out_o (lowest)
  );

  assign capture  = en & gs_i;
  assign retire   = (state_q == ST_OFFER) & gnt_ready_i;
  assign cap_mask = capture ? ({{(N-1){1'b0}}, 1'b1} << code_i) : '0;
  assign ret_mask = retire ? gnt_q : '0;
  // Bits surviving this edge's retire; a capture hitting one of these is a duplicate.
  assign kept_mask = pend_q & ~ret_mask;

  always_comb begin
    out_d  = cap_mask;
    pend_d = kept_mask | cap_mask;
    drop_d = |(kept_mask & cap_mask);
    eno_d  = en & (pend_d == '0);
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (pend_q != '0) begin
          gnt_d   = lowest;
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (gnt_ready_i) begin
          gnt_d   = '0;
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d = ST_IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      pend_q  <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      eno_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      pend_q  <= pend_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      eno_q   <= eno_d;
      drop_q  <= drop_d;
    end
  end

  assign out_o       = out_q;
  assign pend_o      = pend_q;
  assign gnt_o       = gnt_q;
  assign gnt_valid_o = (state_q == ST_OFFER);
  assign eno_o       = eno_q;
  assign drop_o      = drop_q;
  assign cnt_o       = cnt_q;
  assign dbg_state_o = state_q;

endmodule
